// File: rtl/voice_alloc_pkg.sv
// Shared types for the polyphony scheduler and the tone generator bank.
package voice_alloc_pkg;

    // Default widths of one voice record as seen by the tone generators.
    localparam int VOICE_NOTE_W = 8;
    localparam int VOICE_AGE_W  = 4;

    // Note code reserved for "no note"; events carrying it are dropped.
    localparam int NOTE_NONE = 0;

    // Allocator sequencing: wait for an event, walk the voices, apply the decision.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // One voice as consumed by an oscillator + envelope pair.
    typedef struct packed {
        logic [VOICE_NOTE_W-1:0] note;
        logic                    gate;
        logic [VOICE_AGE_W-1:0]  age;
    } voice_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Note event channel from the keycode decoder into the voice allocator.
//
// Handshake: the master raises ev_valid with ev_on/ev_note stable and keeps
// all three unchanged until a rising clk edge sees ev_valid & ev_ready high;
// that edge transfers exactly one event. ev_ready never depends on ev_valid.
interface voice_allocator_if
    import voice_alloc_pkg::*;
#(
    parameter int NOTE_W = VOICE_NOTE_W
);
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [NOTE_W-1:0] ev_note;

    modport master (output ev_valid, ev_on, ev_note, input ev_ready);
    modport slave  (input ev_valid, ev_on, ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator_slot.sv
// One synth voice: note/gate/age record plus the one-cycle start pulse.
module voice_slot #(
    parameter int NOTE_W = 8,
    parameter int AGE_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_assign,   // (re)start this voice on i_note
    input  logic              i_release,  // gate off, keep note for the release phase
    input  logic              i_bump,     // another voice started: grow older
    input  logic [NOTE_W-1:0] i_note,
    output logic [NOTE_W-1:0] o_note,
    output logic              o_gate,
    output logic [AGE_W-1:0]  o_age,
    output logic              o_trig
);
    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic              gate;
        logic [AGE_W-1:0]  age;
    } slot_t;

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    slot_t r_voice;
    logic  r_trig;

    // Apply the commit command; assign wins over bump, age saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_voice <= '0;
            r_trig  <= 1'b0;
        end else begin
            r_trig <= i_assign;
            if (i_assign) begin
                r_voice.note <= i_note;
                r_voice.gate <= 1'b1;
                r_voice.age  <= '0;
            end else if (i_release) begin
                r_voice.gate <= 1'b0;
            end else if (i_bump && r_voice.gate && (r_voice.age != AGE_MAX)) begin
                r_voice.age <= r_voice.age + 1'b1;
            end
        end
    end

    assign o_note = r_voice.note;
    assign o_gate = r_voice.gate;
    assign o_age  = r_voice.age;
    assign o_trig = r_trig;

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: latches one note event, walks the voices one per cycle
// to find a retrigger match / lowest free / oldest sounding voice, then
// commits the decision to the voice slots in a single cycle.
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = VOICE_NOTE_W,
    parameter int AGE_W      = VOICE_AGE_W
) (
    input  logic                             clk,
    input  logic                             reset_n,
    voice_allocator_if.slave                 ev,
    output logic [NUM_VOICES*NOTE_W-1:0]     voice_note,
    output logic [NUM_VOICES-1:0]            voice_gate,
    output logic [NUM_VOICES-1:0]            voice_trig,
    output logic                             steal_pulse,
    output logic [$clog2(NUM_VOICES+1)-1:0]  active_count,
    output state_t                           dbg_state
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_run;
    logic               r_ev_on;
    logic [NOTE_W-1:0]  r_ev_note;
    logic [IDX_W-1:0]   r_idx;
    logic               r_match_found;
    logic [IDX_W-1:0]   r_match_idx;
    logic               r_free_found;
    logic [IDX_W-1:0]   r_free_idx;
    logic               r_old_found;
    logic [IDX_W-1:0]   r_old_idx;
    logic [AGE_W-1:0]   r_old_age;
    logic               r_steal;
    logic [CNT_W-1:0]   r_count;

    logic [NOTE_W-1:0]     w_note [NUM_VOICES];
    logic [AGE_W-1:0]      w_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_gate;
    logic [NUM_VOICES-1:0] w_trig;
    logic [NUM_VOICES-1:0] w_assign;
    logic [NUM_VOICES-1:0] w_release;
    logic [NUM_VOICES-1:0] w_gate_nxt;
    logic                  w_bump;
    logic                  w_steal;
    logic                  w_accept;
    logic [IDX_W-1:0]      w_target;
    logic [CNT_W-1:0]      w_count_nxt;

    // r_run keeps ev_ready low while reset is held and for the release edge.
    assign ev.ev_ready = r_run && (r_state == IDLE);
    assign w_accept    = ev.ev_valid && ev.ev_ready;

    // Next state and the commit decision (target voice, slot commands, steal flag).
    always_comb begin
        w_state_nxt = r_state;
        w_target    = r_free_idx;
        w_assign    = '0;
        w_release   = '0;
        w_bump      = 1'b0;
        w_steal     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && (ev.ev_note != NOTE_W'(NOTE_NONE))) begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                w_state_nxt = IDLE;
                if (r_match_found) begin
                    w_target = r_match_idx;
                end else if (r_free_found) begin
                    w_target = r_free_idx;
                end else begin
                    w_target = r_old_idx;
                end
                if (r_ev_on) begin
                    w_assign[w_target] = 1'b1;
                    w_bump             = 1'b1;
                    w_steal            = !r_match_found && !r_free_found;
                end else if (r_match_found) begin
                    w_release[r_match_idx] = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gate vector after this commit and its population count.
    always_comb begin
        w_gate_nxt  = (w_gate | w_assign) & ~w_release;
        w_count_nxt = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_count_nxt = w_count_nxt + CNT_W'(w_gate_nxt[i]);
        end
    end

    // State register, event latch and scan candidate tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_run         <= 1'b0;
            r_ev_on       <= 1'b0;
            r_ev_note     <= '0;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
            r_steal       <= 1'b0;
            r_count       <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_nxt;
            r_steal <= w_steal;
            if ((r_state == IDLE) && w_accept) begin
                r_ev_on       <= ev.ev_on;
                r_ev_note     <= ev.ev_note;
                r_idx         <= '0;
                r_match_found <= 1'b0;
                r_free_found  <= 1'b0;
                r_old_found   <= 1'b0;
            end
            if (r_state == SCAN) begin
                // Ascending walk: the first hit is the lowest index.
                if (!r_match_found && w_gate[r_idx] && (w_note[r_idx] == r_ev_note)) begin
                    r_match_found <= 1'b1;
                    r_match_idx   <= r_idx;
                end
                if (!r_free_found && !w_gate[r_idx]) begin
                    r_free_found <= 1'b1;
                    r_free_idx   <= r_idx;
                end
                // Strictly greater keeps the lowest index on an age tie.
                if (w_gate[r_idx] && (!r_old_found || (w_age[r_idx] > r_old_age))) begin
                    r_old_found <= 1'b1;
                    r_old_idx   <= r_idx;
                    r_old_age   <= w_age[r_idx];
                end
                if (r_idx != LAST_IDX) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (r_state == COMMIT) begin
                r_count <= w_count_nxt;
            end
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        voice_slot #(
            .NOTE_W (NOTE_W),
            .AGE_W  (AGE_W)
        ) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_assign  (w_assign[i]),
            .i_release (w_release[i]),
            .i_bump    (w_bump),
            .i_note    (r_ev_note),
            .o_note    (w_note[i]),
            .o_gate    (w_gate[i]),
            .o_age     (w_age[i]),
            .o_trig    (w_trig[i])
        );
        assign voice_note[i*NOTE_W +: NOTE_W] = w_note[i];
    end

    assign voice_gate   = w_gate;
    assign voice_trig   = w_trig;
    assign steal_pulse  = r_steal;
    assign active_count = r_count;
    assign dbg_state    = r_state;

endmodule
